// File: rtl/rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_pkg
//   Shared types and the rotate-priority pick function for the round-robin
//   grant controller.
//
//   arb_state_t : controller state (IDLE = no owner, OWN = grant issued)
//   rr_pick_t   : result of one rotate-priority scan (any / idx / onehot)
//   rr_pick()   : scans req starting at ptr, wrapping modulo n_req, and
//                 returns the first requester found.
//
//   The function works on a fixed maximum width (RR_MAX_REQ requesters) so
//   that one definition serves every instance size. Callers zero-extend their
//   request vector and truncate the result back to their own width.
// ----------------------------------------------------------------------------
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Largest requester count the shared pick function supports.
  localparam int RR_MAX_REQ   = 32;
  localparam int RR_MAX_IDX_W = 5;

  typedef struct packed {
    logic                    any;
    logic [RR_MAX_IDX_W-1:0] idx;
    logic [RR_MAX_REQ-1:0]   onehot;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... (mod n_req).
  // ptr is expected to be < n_req; bits of req at or above n_req are ignored.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX_REQ-1:0] req,
    input int unsigned           n_req,
    input int unsigned           ptr
  );
    rr_pick_t    res;
    int unsigned slot;
    // NOTE: every combinational target gets a default before any branch so
    // that no path leaves it unassigned; that is what keeps logic latch-free.
    res  = '0;
    slot = 0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      if (i < n_req && !res.any) begin
        // Wrap by subtraction: ptr + i < 2 * n_req, so one correction suffices.
        slot = ptr + i;
        if (slot >= n_req) begin
          slot = slot - n_req;
        end
        if (req[slot]) begin
          res.any    = 1'b1;
          res.idx    = RR_MAX_IDX_W'(slot);
          res.onehot = RR_MAX_REQ'(1) << slot;
        end
      end
    end
    return res;
  endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_pick_comb.sv
// ----------------------------------------------------------------------------
// rr_pick_comb
//   Pure combinational rotate-priority encoder. Finds the first asserted
//   request at or after i_ptr, wrapping from N_REQ-1 back to 0.
//
//   Parameters
//     N_REQ  number of requesters (1 .. RR_MAX_REQ)
//     IDX_W  width of the pointer / index
//   Ports
//     i_req     in   N_REQ   request vector
//     i_ptr     in   IDX_W   highest-priority requester for this scan
//     o_onehot  out  N_REQ   one-hot selected requester (0 when none)
//     o_idx     out  IDX_W   binary index of the selected requester
//     o_any     out  1       at least one request present
// ----------------------------------------------------------------------------
module rr_pick_comb
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  rr_pick_t w_pick;

  always_comb begin
    w_pick = rr_pick(RR_MAX_REQ'(i_req), N_REQ, 32'(i_ptr));
  end

  // The upper bits of the wide result are always zero for this instance
  // size, so truncating back to the local widths loses nothing.
  assign o_onehot = N_REQ'(w_pick.onehot);
  assign o_idx    = IDX_W'(w_pick.idx);
  assign o_any    = w_pick.any;

endmodule : rr_pick_comb

// File: rtl/rr_grant_ctrl.sv
// ----------------------------------------------------------------------------
// rr_grant_ctrl
//   Round-robin arbiter sharing one downstream resource among N_REQ
//   requesters. A single owner holds a one-hot grant until it signals done,
//   drops its request, or has held the grant for MAX_HOLD cycles. Priority
//   then rotates to the requester after the previous owner. There is always
//   at least one cycle with no grant between two owners.
//
//   Parameters
//     N_REQ     number of requesters (1 .. 32)
//     MAX_HOLD  max cycles one grant is held; 0 disables the limit
//     IDX_W     derived width of grant_idx (not overridable)
//   Ports
//     clk        in   1       rising-edge clock
//     rst_n      in   1       asynchronous active-low reset
//     req        in   N_REQ   level request per requester
//     done       in   1       owner finished; ignored while idle
//     grant      out  N_REQ   one-hot grant, registered
//     grant_vld  out  1       |grant, registered
//     grant_idx  out  IDX_W   index of current/last owner (held while idle)
//     timeout    out  1       one-cycle pulse when MAX_HOLD alone forced a
//                             release
// ----------------------------------------------------------------------------
module rr_grant_ctrl
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout
);

  // Hold counter only needs to reach MAX_HOLD-1; with no limit it simply
  // saturates and is never compared.
  localparam int CNT_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_LAST);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_REQ - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [N_REQ-1:0] r_grant;
  logic             r_grant_vld;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_timeout;

  logic [N_REQ-1:0] w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_owner_req;
  logic             w_hold_hit;
  logic             w_release;
  logic             w_timeout_cause;
  logic [IDX_W-1:0] w_ptr_next;

  rr_pick_comb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Owner still requesting: r_grant is one-hot while OWN, so masking avoids
  // a variable index that could run past N_REQ for non-power-of-2 sizes.
  assign w_owner_req = |(req & r_grant);

  assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold_cnt == CNT_LAST);
  assign w_release   = done || !w_owner_req || w_hold_hit;

  // A timeout is reported only when the limit is the sole reason for release.
  assign w_timeout_cause = w_hold_hit && !done && w_owner_req;

  // Priority moves to the requester after the owner, wrapping at the top.
  assign w_ptr_next = (r_grant_idx == IDX_TOP) ? '0 : r_grant_idx + 1'b1;

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_grant     <= '0;
      r_grant_vld <= 1'b0;
      r_grant_idx <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant     <= w_onehot;
            r_grant_vld <= 1'b1;
            r_grant_idx <= w_idx;
            r_hold_cnt  <= '0;
            r_state     <= OWN;
          end else begin
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
          end
        end
        OWN: begin
          if (w_release) begin
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_timeout   <= w_timeout_cause;
            r_state     <= IDLE;
          end else if (r_hold_cnt != CNT_SAT) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_grant     <= '0;
          r_grant_vld <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_vld = r_grant_vld;
  assign grant_idx = r_grant_idx;
  assign timeout   = r_timeout;

endmodule : rr_grant_ctrl

// File: tb/tb_rr_grant_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_ctrl
//   Self-checking bench for rr_grant_ctrl. Two instances: a 4-requester
//   controller with an 8-cycle hold limit, and a single-requester controller
//   with no limit. Expected outputs come from a cycle-level model that tracks
//   the owner as an integer and counts how many cycles its grant has been
//   visible.
// ----------------------------------------------------------------------------
module tb_rr_grant_ctrl;

  localparam int N_A  = 4;
  localparam int MH_A = 8;
  localparam int N_B  = 1;
  localparam int MH_B = 0;

  typedef struct {
    int owner;  // -1 when nobody holds the grant
    int ptr;    // first requester examined at the next arbitration
    int held;   // cycles the current grant has been visible
    int idx;    // last owner
    bit to;     // timeout pulse expected this cycle
  } model_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic       timeout;

  logic [0:0] req_b;
  logic       done_b;
  logic [0:0] grant_b;
  logic       grant_vld_b;
  logic [0:0] grant_idx_b;
  logic       timeout_b;

  int n_checks = 0;
  int n_pass   = 0;

  model_t ma;
  model_t mb;

  rr_grant_ctrl #(.N_REQ(N_A), .MAX_HOLD(MH_A)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .timeout   (timeout)
  );

  rr_grant_ctrl #(.N_REQ(N_B), .MAX_HOLD(MH_B)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_b),
    .done      (done_b),
    .grant     (grant_b),
    .grant_vld (grant_vld_b),
    .grant_idx (grant_idx_b),
    .timeout   (timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.owner = -1;
    m.ptr   = 0;
    m.held  = 0;
    m.idx   = 0;
    m.to    = 1'b0;
    return m;
  endfunction

  // One rising edge of the controller, from the rules of the arbiter.
  function automatic model_t model_next(model_t s, int n, int mh, logic [3:0] r, logic d);
    model_t t;
    bit     found;
    bit     drop;
    bit     lim;
    t     = s;
    t.to  = 1'b0;
    found = 1'b0;
    drop  = 1'b0;
    lim   = 1'b0;
    if (s.owner < 0) begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (s.ptr + k) % n;
        if (!found && r[c]) begin
          found   = 1'b1;
          t.owner = c;
          t.idx   = c;
          t.held  = 1;
        end
      end
    end else begin
      drop = !r[s.owner];
      lim  = (mh != 0) && (s.held == mh);
      if (d || drop || lim) begin
        t.to    = lim && !d && !drop;
        t.ptr   = (s.owner + 1) % n;
        t.owner = -1;
        t.held  = 0;
      end else begin
        t.held = s.held + 1;
      end
    end
    return t;
  endfunction

  function automatic logic [3:0] exp_grant(model_t m);
    return (m.owner >= 0) ? 4'(1 << m.owner) : 4'b0000;
  endfunction

  task automatic verify(input string tag);
    check({tag, " grant"},     32'(grant),       32'(exp_grant(ma)));
    check({tag, " vld"},       32'(grant_vld),   32'(ma.owner >= 0));
    check({tag, " idx"},       32'(grant_idx),   32'(ma.idx));
    check({tag, " timeout"},   32'(timeout),     32'(ma.to));
    check({tag, " b_grant"},   32'(grant_b),     32'(exp_grant(mb)));
    check({tag, " b_vld"},     32'(grant_vld_b), 32'(mb.owner >= 0));
    check({tag, " b_idx"},     32'(grant_idx_b), 32'(mb.idx));
    check({tag, " b_timeout"}, 32'(timeout_b),   32'(mb.to));
  endtask

  // Advance one clock: update the model with the inputs seen at the edge,
  // then compare just after the edge. Inputs change only after this returns.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      ma = model_next(ma, N_A, MH_A, req, done);
      mb = model_next(mb, N_B, MH_B, {3'b000, req_b}, done_b);
    end
    #1;
    verify(tag);
  endtask

  initial begin
    int ng;
    int nt;

    ma     = model_reset();
    mb     = model_reset();
    rst_n  = 1'b0;
    req    = 4'hF;
    done   = 1'b0;
    req_b  = 1'b0;
    done_b = 1'b0;

    // 1: reset with all requests pending, then first grant after release.
    tick("t1_rst");
    tick("t1_rst");
    rst_n = 1'b1;
    req   = 4'b0101;
    tick("t1_first");
    check("t1_first_grant_const", 32'(grant), 32'h1);

    // 2: everyone requesting, done held high -> rotating grants with a gap.
    req  = 4'hF;
    done = 1'b1;
    for (int i = 0; i < 10; i++) tick("t2_rotate");
    done = 1'b0;

    // 3: single requester held with no done -> forced release after 8 cycles.
    req = 4'b0000;
    tick("t3_idle");
    tick("t3_idle");
    req = 4'b0100;
    ng  = 0;
    nt  = 0;
    for (int i = 0; i < 9; i++) begin
      tick("t3_hold");
      if (grant == 4'b0100) ng++;
      if (timeout) nt++;
    end
    check("t3_hold_cycles", 32'(ng), 32'd8);
    check("t3_timeouts", 32'(nt), 32'd1);
    tick("t3_regrant");
    check("t3_regrant_const", 32'(grant), 32'h4);

    // 4a: owner drops its request -> release without timeout.
    req = 4'b0000;
    tick("t4_idle");
    tick("t4_idle");
    req = 4'hF;
    tick("t4_grant");
    req = 4'hF & ~exp_grant(ma);
    tick("t4_drop");
    check("t4_drop_grant_const", 32'(grant), 32'h0);
    check("t4_drop_to_const", 32'(timeout), 32'h0);

    // 4b: done coincides with the hold limit -> no timeout pulse.
    req = 4'hF;
    tick("t4_regrant");
    for (int i = 0; i < 20 && ma.owner >= 0 && ma.held < MH_A; i++) tick("t4_hold");
    done = 1'b1;
    tick("t4_done_at_limit");
    check("t4_limit_to_const", 32'(timeout), 32'h0);
    check("t4_limit_grant_const", 32'(grant), 32'h0);
    done = 1'b0;

    // 5: asynchronous reset while requester 1 owns the grant.
    req = 4'b0010;
    tick("t5_grant");
    tick("t5_grant");
    check("t5_owner_const", 32'(grant), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    ma = model_reset();
    mb = model_reset();
    check("t5_async_grant", 32'(grant), 32'h0);
    check("t5_async_vld", 32'(grant_vld), 32'h0);
    verify("t5_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0110;
    tick("t5_after");
    check("t5_after_const", 32'(grant), 32'h2);

    // 6: single requester, no hold limit -> grant never drops.
    req   = 4'b0000;
    req_b = 1'b1;
    ng    = 0;
    nt    = 0;
    for (int i = 0; i < 100; i++) begin
      tick("t6_single");
      if (grant_b == 1'b1) ng++;
      if (timeout_b) nt++;
    end
    check("t6_grant_cycles", 32'(ng), 32'd100);
    check("t6_timeouts", 32'(nt), 32'd0);

    // Random traffic: requests mostly held so hold limits are reached too.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) req_b = 1'($urandom_range(0, 1));
      done_b = ($urandom_range(0, 9) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rr_grant_ctrl
